// File: rtl/key_input_buffer.sv
// Keyboard front-end: case-folds received bytes, queues them in a first-word
// fall-through FIFO and keeps a timed "held key" for continuous player motion.
module key_input_buffer #(
    parameter int DEPTH       = 8,
    parameter int ADDR_W      = 3,
    parameter int HOLD_CYCLES = 2_500_000,
    parameter int CASE_FOLD   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxDone,
    input  logic [7:0]        rxByte,
    input  logic              rd_en,
    input  logic              clr_ovf,
    output logic [7:0]        rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [7:0]        held_key,
    output logic              key_valid
);

    localparam int                  TIMER_W    = $clog2(HOLD_CYCLES) + 1;
    localparam logic [TIMER_W-1:0]  TIMER_LOAD = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [ADDR_W:0]     DEPTH_CNT  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {IDLE, HOLD} hold_state_t;

    logic [7:0]         mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [ADDR_W:0]    count_reg, count_next;
    logic               empty_reg, full_reg;
    logic               overflow_reg, overflow_next;

    hold_state_t        state_reg, state_next;
    logic [7:0]         held_reg, held_next;
    logic               key_valid_reg;
    logic [TIMER_W-1:0] timer_reg, timer_next;

    logic [7:0]         filt_byte;
    logic               accept, do_read, do_write;

    always_comb begin
        filt_byte = rxByte;
        if (CASE_FOLD != 0 && rxByte >= 8'h41 && rxByte <= 8'h5A)
            filt_byte = rxByte | 8'h20;
    end

    assign accept   = rxDone && (filt_byte != 8'h00);
    assign do_read  = rd_en && (count_reg != '0);
    // A pop in the same cycle frees a slot, so a write into a full FIFO succeeds.
    assign do_write = accept && ((count_reg != DEPTH_CNT) || do_read);

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        if (do_write)
            wr_ptr_next = wr_ptr_reg + 1'b1;
        if (do_read)
            rd_ptr_next = rd_ptr_reg + 1'b1;
        case ({do_write, do_read})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
        if (accept && !do_write)
            overflow_next = 1'b1;
        else if (clr_ovf)
            overflow_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (do_write)
            mem[wr_ptr_reg] <= filt_byte;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            empty_reg    <= 1'b1;
            full_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            empty_reg    <= (count_next == '0);
            full_reg     <= (count_next == DEPTH_CNT);
            overflow_reg <= overflow_next;
        end
    end

    // Hold machine: a new key always replaces the old one and restarts the timer.
    always_comb begin
        state_next = state_reg;
        held_next  = held_reg;
        timer_next = timer_reg;
        if (accept) begin
            state_next = HOLD;
            held_next  = filt_byte;
            timer_next = TIMER_LOAD;
        end else if (state_reg == HOLD) begin
            if (timer_reg == '0) begin
                state_next = IDLE;
                held_next  = 8'h00;
            end else begin
                timer_next = timer_reg - TIMER_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            held_reg      <= 8'h00;
            key_valid_reg <= 1'b0;
            timer_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            held_reg      <= held_next;
            key_valid_reg <= (held_next != 8'h00);
            timer_reg     <= timer_next;
        end
    end

    // Masking with empty hides stale memory words left behind by pops or reset.
    assign rd_data   = empty_reg ? 8'h00 : mem[rd_ptr_reg];
    assign empty     = empty_reg;
    assign full      = full_reg;
    assign count     = count_reg;
    assign overflow  = overflow_reg;
    assign held_key  = held_reg;
    assign key_valid = key_valid_reg;

endmodule

// File: tb/tb_key_input_buffer.sv
// Directed bench for key_input_buffer: a queue scoreboard predicts FIFO heads
// and a small reference tracks overflow and the held key.
module tb_key_input_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int HOLD   = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              rxDone;
    logic [7:0]        rxByte;
    logic              rd_en;
    logic              clr_ovf;
    logic [7:0]        rd_data;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic [7:0]        held_key;
    logic              key_valid;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb[$];
    logic       exp_ovf;
    logic [7:0] exp_held;
    int         exp_timer;

    key_input_buffer #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .HOLD_CYCLES(HOLD), .CASE_FOLD(1)
    ) dut (
        .clk(clk), .rst(rst), .rxDone(rxDone), .rxByte(rxByte),
        .rd_en(rd_en), .clr_ovf(clr_ovf), .rd_data(rd_data),
        .empty(empty), .full(full), .count(count), .overflow(overflow),
        .held_key(held_key), .key_valid(key_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] fold(input logic [7:0] b);
        if (b >= 8'h41 && b <= 8'h5A) return b + 8'h20;
        return b;
    endfunction

    task automatic check_all(input string tag);
        logic [7:0] head;
        head = (sb.size() != 0) ? sb[0] : 8'h00;
        chk({tag, ".count"},    32'(count),     32'(sb.size()));
        chk({tag, ".empty"},    32'(empty),     32'(sb.size() == 0));
        chk({tag, ".full"},     32'(full),      32'(sb.size() == DEPTH));
        chk({tag, ".rd_data"},  32'(rd_data),   32'(head));
        chk({tag, ".overflow"}, 32'(overflow),  32'(exp_ovf));
        chk({tag, ".held_key"}, 32'(held_key),  32'(exp_held));
        chk({tag, ".key_valid"},32'(key_valid), 32'(exp_held != 8'h00));
    endtask

    // One clock cycle: predict, drive, clock, then sample 1 time unit after the edge.
    task automatic step(input string tag, input logic dn, input logic [7:0] b,
                        input logic rd, input logic clr);
        logic [7:0] f, popped;
        logic acc, do_rd, do_wr;
        f     = fold(b);
        acc   = dn && (f != 8'h00);
        do_rd = rd && (sb.size() != 0);
        if (do_rd) begin
            chk({tag, ".pop"}, 32'(rd_data), 32'(sb[0]));
            popped = sb.pop_front();
        end
        do_wr = acc && (sb.size() < DEPTH);
        if (do_wr) sb.push_back(f);
        if (acc && !do_wr) exp_ovf = 1'b1;
        else if (clr)      exp_ovf = 1'b0;
        if (acc) begin
            exp_held  = f;
            exp_timer = HOLD - 1;
        end else if (exp_held != 8'h00) begin
            if (exp_timer == 0) exp_held = 8'h00;
            else                exp_timer--;
        end
        rxDone = dn; rxByte = b; rd_en = rd; clr_ovf = clr;
        @(posedge clk);
        #1;
        rxDone = 1'b0; rxByte = 8'h00; rd_en = 1'b0; clr_ovf = 1'b0;
        $display("step %s: dn=%0b byte=%02h rd=%0b clr=%0b -> count=%0d rd_data=%02h ovf=%0b held=%02h",
                 tag, dn, b, rd, clr, count, rd_data, overflow, held_key);
        check_all(tag);
    endtask

    task automatic model_reset();
        sb.delete();
        exp_ovf   = 1'b0;
        exp_held  = 8'h00;
        exp_timer = 0;
    endtask

    initial begin
        rst = 1'b0; rxDone = 1'b0; rxByte = 8'h00; rd_en = 1'b0; clr_ovf = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;

        // 1: idle after reset
        for (int i = 0; i < 100; i++) step("idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // 2: 'W' folds to 'w', held for exactly HOLD cycles
        step("fold_W", 1'b1, 8'h57, 1'b0, 1'b0);
        chk("fold_W.rd_data_const", 32'(rd_data), 32'h77);
        chk("fold_W.held_const", 32'(held_key), 32'h77);
        for (int i = 2; i <= HOLD + 1; i++) begin
            step("hold_W", 1'b0, 8'h00, 1'b0, 1'b0);
            chk("hold_W.const", 32'(held_key), (i <= HOLD) ? 32'h77 : 32'h00);
        end
        step("drain_w", 1'b0, 8'h00, 1'b1, 1'b0);

        // 3: overflow on the fifth write, drain, clear sticky flag
        for (int i = 0; i < 5; i++) step("fill5", 1'b1, 8'h61 + 8'(i), 1'b0, 1'b0);
        chk("fill5.ovf_const", 32'(overflow), 32'h1);
        for (int i = 0; i < 4; i++) step("pop4", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("pop4.empty_const", 32'(empty), 32'h1);
        step("clr_ovf", 1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_ovf.const", 32'(overflow), 32'h0);

        // 4: full with simultaneous pop and write, then drain across the wrap
        for (int i = 0; i < 4; i++) step("fill4", 1'b1, 8'h61 + 8'(i), 1'b0, 1'b0);
        step("rw_full", 1'b1, 8'h7A, 1'b1, 1'b0);
        chk("rw_full.count_const", 32'(count), 32'd4);
        chk("rw_full.ovf_const", 32'(overflow), 32'h0);
        for (int i = 0; i < 4; i++) step("drain4", 1'b0, 8'h00, 1'b1, 1'b0);

        // 4b: write+read while holding one entry, and write+read while empty
        step("one", 1'b1, 8'h31, 1'b0, 1'b0);
        step("rw_mid", 1'b1, 8'h32, 1'b1, 1'b0);
        step("pop_mid", 1'b0, 8'h00, 1'b1, 1'b0);
        step("rw_empty", 1'b1, 8'h33, 1'b1, 1'b0);
        chk("rw_empty.count_const", 32'(count), 32'd1);
        step("pop_last", 1'b0, 8'h00, 1'b1, 1'b0);

        // 5: null byte and pop while empty are ignored
        for (int i = 0; i < HOLD + 2; i++) step("settle", 1'b0, 8'h00, 1'b0, 1'b0);
        step("null_rd", 1'b1, 8'h00, 1'b1, 1'b0);
        chk("null_rd.count_const", 32'(count), 32'd0);
        chk("null_rd.held_const", 32'(held_key), 32'h00);

        // 6: replacement key restarts the hold window
        step("key_a", 1'b1, 8'h61, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step("gap", 1'b0, 8'h00, 1'b0, 1'b0);
        step("key_d", 1'b1, 8'h64, 1'b0, 1'b0);
        chk("key_d.held_const", 32'(held_key), 32'h64);
        for (int i = 2; i <= HOLD + 1; i++) begin
            step("hold_d", 1'b0, 8'h00, 1'b0, 1'b0);
            chk("hold_d.const", 32'(held_key), (i <= HOLD) ? 32'h64 : 32'h00);
        end

        // 6b: asynchronous reset mid-hold with data queued
        step("key_x", 1'b1, 8'h58, 1'b0, 1'b0);
        step("gap2", 1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        $display("step async_rst: held=%02h empty=%0b count=%0d", held_key, empty, count);
        check_all("async_rst");
        chk("async_rst.held_const", 32'(held_key), 32'h00);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step("post_rst", 1'b0, 8'h00, 1'b0, 1'b0);
        step("post_rst_wr", 1'b1, 8'h42, 1'b0, 1'b0);
        step("post_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
